// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
//
// Parametrised UART receiver. The serial line is brought into the clock
// domain through a two-flop synchroniser. Each bit is sampled three times
// around its centre, and the majority of the three samples gives the bit
// value. The receiver supports 5..9 data bits (LSB first), none/even/odd
// parity and 1 or 2 stop bits. It reports parity errors, framing errors and
// line breaks.
//
// Ports
//   i_Clock      : system clock, rising edge
//   i_Reset      : asynchronous, active-high reset
//   i_RX_Serial  : asynchronous serial line, idle high
//   o_RX_DV      : one-cycle pulse when a frame completes
//   o_RX_Byte    : received data, right-aligned, held until the next pulse
//   o_Parity_Err : parity mismatch for the frame, valid with o_RX_DV
//   o_Frame_Err  : a stop bit was received as 0, valid with o_RX_DV
//   o_Break      : break detected (all votes 0), valid with o_RX_DV
//   o_Busy       : high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_RX_Serial,
   output logic                 o_RX_DV,
   output logic [DATA_BITS-1:0] o_RX_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int M  = (CLKS_PER_BIT - 1) / 2;

   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_SAMP0 = CW'(M - 1);
   localparam logic [CW-1:0] CNT_SAMP1 = CW'(M);
   localparam logic [CW-1:0] CNT_VOTE  = CW'(M + 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } state_t;

   logic                 sync1_q;
   logic                 sync2_q;
   logic [1:0]           settle_q;
   logic                 armed_q;
   logic                 rxS;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           bitIdx_q, bitIdx_d;
   logic                 stopIdx_q, stopIdx_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parityPend_q, parityPend_d;
   logic                 framePend_q, framePend_d;
   logic                 allZero_q, allZero_d;
   logic                 rxDv_q, rxDv_d;
   logic [DATA_BITS-1:0] rxByte_q, rxByte_d;
   logic                 parityErr_q, parityErr_d;
   logic                 frameErr_q, frameErr_d;
   logic                 break_q, break_d;

   logic                 vote;
   logic                 isVote;
   logic                 isLast;
   logic                 expParity;
   logic                 breakNow;

   assign rxS = sync2_q;

   // Two-flop synchroniser for the serial pin, plus an arming flag. The sync
   // flops come out of reset holding 1, so they look idle even when the real
   // line is low. settle_q waits until the second flop holds a genuine line
   // sample. Start detection is only armed after that genuine sample has been
   // high once. As a result, a line that was low across reset cannot start a
   // frame until it has returned to idle.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         settle_q <= 2'b00;
         armed_q  <= 1'b0;
      end else begin
         sync1_q  <= i_RX_Serial;
         sync2_q  <= sync1_q;
         settle_q <= {settle_q[0], 1'b1};
         if (settle_q[1] && sync2_q) begin
            armed_q <= 1'b1;
         end
      end
   end

   // Majority of the samples taken at M-1 and M and the live sample at M+1.
   // isVote marks the cycle in which that decision is made.
   assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxS) | (samp_q[1] & rxS);
   assign isVote    = (cnt_q == CNT_VOTE);
   assign isLast    = (cnt_q == CNT_LAST);
   assign expParity = (PARITY == 2) ? ~(^shift_q) : (^shift_q);
   assign breakNow  = allZero_q & ~vote;

   // State and datapath registers. Everything here moves only through the
   // next-state values computed below.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bitIdx_q     <= '0;
         stopIdx_q    <= 1'b0;
         samp_q       <= '0;
         shift_q      <= '0;
         parityPend_q <= 1'b0;
         framePend_q  <= 1'b0;
         allZero_q    <= 1'b0;
         rxDv_q       <= 1'b0;
         rxByte_q     <= '0;
         parityErr_q  <= 1'b0;
         frameErr_q   <= 1'b0;
         break_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bitIdx_q     <= bitIdx_d;
         stopIdx_q    <= stopIdx_d;
         samp_q       <= samp_d;
         shift_q      <= shift_d;
         parityPend_q <= parityPend_d;
         framePend_q  <= framePend_d;
         allZero_q    <= allZero_d;
         rxDv_q       <= rxDv_d;
         rxByte_q     <= rxByte_d;
         parityErr_q  <= parityErr_d;
         frameErr_q   <= frameErr_d;
         break_q      <= break_d;
      end
   end

   // Frame sequencing. The bit counter free-runs through each bit period. The
   // state-specific code only decides what happens at the vote point and at
   // the end of each bit. The final stop bit ends at the vote point, not at
   // the end of the bit. This leaves half a bit of margin for the next start
   // edge when the frames are sent back to back.
   always_comb begin
      state_d      = state_q;
      bitIdx_d     = bitIdx_q;
      stopIdx_d    = stopIdx_q;
      samp_d       = samp_q;
      shift_d      = shift_q;
      parityPend_d = parityPend_q;
      framePend_d  = framePend_q;
      allZero_d    = allZero_q;
      rxDv_d       = 1'b0;
      rxByte_d     = rxByte_q;
      parityErr_d  = parityErr_q;
      frameErr_d   = frameErr_q;
      break_d      = break_q;
      cnt_d        = isLast ? '0 : cnt_q + CW'(1);

      if (cnt_q == CNT_SAMP0) begin
         samp_d[0] = rxS;
      end
      if (cnt_q == CNT_SAMP1) begin
         samp_d[1] = rxS;
      end

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rxS && armed_q) begin
               state_d      = ST_START;
               cnt_d        = CW'(1);
               bitIdx_d     = '0;
               stopIdx_d    = 1'b0;
               parityPend_d = 1'b0;
               framePend_d  = 1'b0;
               allZero_d    = 1'b1;
            end
         end

         ST_START: begin
            if (isVote && vote) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (isLast) begin
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (isVote) begin
               shift_d = {vote, shift_q[DATA_BITS-1:1]};
               if (vote) begin
                  allZero_d = 1'b0;
               end
            end
            if (isLast) begin
               if (bitIdx_q == DATA_LAST) begin
                  bitIdx_d = '0;
                  state_d  = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 4'd1;
               end
            end
         end

         ST_PARITY: begin
            if (isVote) begin
               if (vote != expParity) begin
                  parityPend_d = 1'b1;
               end
               if (vote) begin
                  allZero_d = 1'b0;
               end
            end
            if (isLast) begin
               state_d = ST_STOP;
            end
         end

         ST_STOP: begin
            if (isVote) begin
               if (!vote) begin
                  framePend_d = 1'b1;
               end else begin
                  allZero_d = 1'b0;
               end
               if (stopIdx_q == STOP_LAST) begin
                  rxDv_d      = 1'b1;
                  rxByte_d    = shift_q;
                  parityErr_d = parityPend_q;
                  frameErr_d  = framePend_q | ~vote;
                  break_d     = breakNow;
                  state_d     = breakNow ? ST_WAIT_HIGH : ST_IDLE;
                  cnt_d       = '0;
               end
            end else if (isLast) begin
               stopIdx_d = 1'b1;
            end
         end

         ST_WAIT_HIGH: begin
            cnt_d = '0;
            if (rxS) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign o_RX_DV      = rxDv_q;
   assign o_RX_Byte    = rxByte_q;
   assign o_Parity_Err = parityErr_q;
   assign o_Frame_Err  = frameErr_q;
   assign o_Break      = break_q;
   assign o_Busy       = (state_q != ST_IDLE);

endmodule
